// File: rtl/intr_eoi_queue_if.sv
// Bus-controller and CPU-facing signals of the interrupt EOI queue.
// slave is the queue itself; master is whatever drives it (controller + CPU, or a bench).
interface intr_eoi_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          INTERRUPT;
  logic          MOD_R;
  logic [127:0]  MOD_READ_DATA;
  logic          MOD_EN;
  logic          MOD_WR;
  logic [15:0]   MOD_A;
  logic [127:0]  MOD_WRITE_DATA;
  logic          INT_REQ;
  logic [7:0]    INT_VEC;
  logic          INT_SRC;
  logic          INT_ACK;
  logic [CW-1:0] COUNT;
  logic          OVERFLOW;
  logic          ERR;

  modport slave (
    input  INTERRUPT, MOD_R, MOD_READ_DATA, INT_ACK,
    output MOD_EN, MOD_WR, MOD_A, MOD_WRITE_DATA,
           INT_REQ, INT_VEC, INT_SRC, COUNT, OVERFLOW, ERR
  );

  modport master (
    output INTERRUPT, MOD_R, MOD_READ_DATA, INT_ACK,
    input  MOD_EN, MOD_WR, MOD_A, MOD_WRITE_DATA,
           INT_REQ, INT_VEC, INT_SRC, COUNT, OVERFLOW, ERR
  );
endinterface

// File: rtl/intr_eoi_queue.sv
// Queues interrupt records captured from the bus controller, offers the head to the CPU,
// and on each acknowledge writes an end-of-interrupt message back to the source device.
module intr_eoi_queue #(
  parameter int          DEPTH        = 4,
  parameter logic [15:0] EOI_ADDR_KBD = 16'h0000,
  parameter logic [15:0] EOI_ADDR_DMA = 16'h0010
) (
  input  logic             BUS_CLK,
  input  logic             RST,
  intr_eoi_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic       src;
    logic [7:0] vec;
  } rec_t;

  typedef enum logic { C_IDLE, C_WAIT } cap_state_t;
  typedef enum logic { E_IDLE, E_BUSY } eoi_state_t;

  cap_state_t    c_state;
  eoi_state_t    e_state;
  rec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          err;
  logic          mod_en;
  logic [15:0]   mod_a;
  logic [7:0]    eoi_vec;

  logic int_req;
  logic pop;
  logic push;
  logic push_ok;
  logic full;
  logic cap_start;
  logic eoi_done;
  rec_t in_rec;

  // Only the vector and source bits of the read buffer carry meaning here.
  logic unused_rd;
  assign unused_rd = ^bus.MOD_READ_DATA[127:9];

  assign full    = (count == CW'(DEPTH));
  assign int_req = (count != '0) && (e_state == E_IDLE);

  // NOTE: always_comb gives every output a value on every path up front, so no latch can form.
  always_comb begin
    in_rec    = '{src: bus.MOD_READ_DATA[8], vec: bus.MOD_READ_DATA[7:0]};
    pop       = int_req && bus.INT_ACK;
    push      = (c_state == C_WAIT) && bus.MOD_R;
    push_ok   = push && (!full || pop);
    cap_start = (c_state == C_IDLE) && bus.INTERRUPT && (e_state == E_IDLE);
    // While capture holds C_WAIT, MOD_R is the capture's completion, never the EOI's.
    eoi_done  = (e_state == E_BUSY) && bus.MOD_R && (c_state == C_IDLE);
  end

  // NOTE: the record array sits on the reset so INT_VEC/INT_SRC read 0 out of reset.
  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register here sample pre-edge values,
      // so a same-edge pop still reads the old head before push overwrites that slot.
      if (push_ok) begin
        mem[wr_ptr] <= in_rec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (push && !push_ok) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      c_state <= C_IDLE;
    end else begin
      case (c_state)
        C_IDLE:  if (cap_start) c_state <= C_WAIT;
        C_WAIT:  if (bus.MOD_R) c_state <= C_IDLE;
        default: c_state <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      e_state <= E_IDLE;
      mod_en  <= 1'b0;
      mod_a   <= '0;
      eoi_vec <= '0;
      err     <= 1'b0;
    end else begin
      if (bus.INTERRUPT && (e_state == E_BUSY)) err <= 1'b1;
      case (e_state)
        E_IDLE: if (pop) begin
          e_state <= E_BUSY;
          mod_en  <= 1'b1;
          mod_a   <= mem[rd_ptr].src ? EOI_ADDR_DMA : EOI_ADDR_KBD;
          eoi_vec <= mem[rd_ptr].vec;
        end
        E_BUSY: if (eoi_done) begin
          e_state <= E_IDLE;
          mod_en  <= 1'b0;
          mod_a   <= '0;
          eoi_vec <= '0;
        end
        default: e_state <= E_IDLE;
      endcase
    end
  end

  assign bus.MOD_EN         = mod_en;
  assign bus.MOD_WR         = mod_en;
  assign bus.MOD_A          = mod_a;
  assign bus.MOD_WRITE_DATA = {120'b0, eoi_vec};
  assign bus.INT_REQ        = int_req;
  assign bus.INT_VEC        = mem[rd_ptr].vec;
  assign bus.INT_SRC        = mem[rd_ptr].src;
  assign bus.COUNT          = count;
  assign bus.OVERFLOW       = overflow;
  assign bus.ERR            = err;
endmodule

// File: tb/tb_intr_eoi_queue.sv
// Directed bench for intr_eoi_queue: capture, ack/EOI, overflow, simultaneous
// push/pop with wrap, error path and asynchronous reset mid-EOI.
module tb_intr_eoi_queue;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  intr_eoi_queue_if #(.DEPTH(4)) bus_if ();

  intr_eoi_queue #(
    .DEPTH       (4),
    .EOI_ADDR_KBD(16'h0000),
    .EOI_ADDR_DMA(16'h0010)
  ) dut (
    .BUS_CLK(clk),
    .RST    (rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic src, input logic [7:0] vec, input int gap);
    bus_if.INTERRUPT = 1'b1;
    tick();
    bus_if.INTERRUPT = 1'b0;
    repeat (gap) tick();
    bus_if.MOD_READ_DATA = {119'b0, src, vec};
    bus_if.MOD_R = 1'b1;
    tick();
    bus_if.MOD_R = 1'b0;
  endtask

  // Acks the head (expected vec/src), checks the EOI request, then completes it.
  task automatic ack_eoi(input string tag, input logic src, input logic [7:0] vec,
                         input logic [2:0] cnt_after);
    check({tag, " int_req"}, bus_if.INT_REQ, 1'b1);
    check({tag, " int_vec"}, bus_if.INT_VEC, vec);
    check({tag, " int_src"}, bus_if.INT_SRC, src);
    bus_if.INT_ACK = 1'b1;
    tick();
    bus_if.INT_ACK = 1'b0;
    check({tag, " mod_en"}, bus_if.MOD_EN, 1'b1);
    check({tag, " mod_wr"}, bus_if.MOD_WR, 1'b1);
    check({tag, " mod_a"}, bus_if.MOD_A, src ? 16'h0010 : 16'h0000);
    check({tag, " mod_wdata"}, bus_if.MOD_WRITE_DATA, {120'b0, vec});
    check({tag, " req_low"}, bus_if.INT_REQ, 1'b0);
    check({tag, " count"}, bus_if.COUNT, cnt_after);
    tick();
    bus_if.MOD_R = 1'b1;
    tick();
    bus_if.MOD_R = 1'b0;
    check({tag, " mod_en_done"}, bus_if.MOD_EN, 1'b0);
    check({tag, " mod_a_done"}, bus_if.MOD_A, 16'h0000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus_if.INTERRUPT     = 1'b0;
    bus_if.MOD_R         = 1'b0;
    bus_if.MOD_READ_DATA = '0;
    bus_if.INT_ACK       = 1'b0;
    rst_n = 1'b0;
    #23;
    check("rst mod_en", bus_if.MOD_EN, 1'b0);
    check("rst int_req", bus_if.INT_REQ, 1'b0);
    check("rst int_vec", bus_if.INT_VEC, 8'h00);
    check("rst count", bus_if.COUNT, 3'd0);
    check("rst overflow", bus_if.OVERFLOW, 1'b0);
    check("rst err", bus_if.ERR, 1'b0);
    check("rst mod_wdata", bus_if.MOD_WRITE_DATA, 128'h0);
    rst_n = 1'b1;
    tick();

    // Single capture, 4 cycles from INTERRUPT to MOD_R
    capture(1'b0, 8'h42, 3);
    check("cap1 int_req", bus_if.INT_REQ, 1'b1);
    check("cap1 int_vec", bus_if.INT_VEC, 8'h42);
    check("cap1 int_src", bus_if.INT_SRC, 1'b0);
    check("cap1 count", bus_if.COUNT, 3'd1);
    ack_eoi("eoi42", 1'b0, 8'h42, 3'd0);

    // DMA record: EOI goes to the DMA address
    capture(1'b1, 8'hA5, 2);
    ack_eoi("eoiA5", 1'b1, 8'hA5, 3'd0);
    check("eoiA5 req_idle", bus_if.INT_REQ, 1'b0);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      capture(1'b0, 8'(i), 1);
      if (i == 4) check("fill4 overflow", bus_if.OVERFLOW, 1'b0);
    end
    check("fill count", bus_if.COUNT, 3'd4);
    check("fill overflow", bus_if.OVERFLOW, 1'b1);
    for (int i = 1; i <= 4; i++) ack_eoi($sformatf("drain%0d", i), 1'b0, 8'(i), 3'(4 - i));
    check("drain count", bus_if.COUNT, 3'd0);
    check("drain req", bus_if.INT_REQ, 1'b0);
    check("drain overflow sticky", bus_if.OVERFLOW, 1'b1);

    // Reset to clear OVERFLOW, then simultaneous push and pop on a full queue
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("rst2 overflow", bus_if.OVERFLOW, 1'b0);
    for (int i = 0; i < 4; i++) capture(i[0], 8'(8'h10 + i), 1);
    check("full count", bus_if.COUNT, 3'd4);
    bus_if.INTERRUPT = 1'b1;
    tick();
    bus_if.INTERRUPT = 1'b0;
    bus_if.MOD_READ_DATA = {119'b0, 1'b1, 8'h77};
    bus_if.MOD_R   = 1'b1;
    bus_if.INT_ACK = 1'b1;
    tick();
    bus_if.MOD_R   = 1'b0;
    bus_if.INT_ACK = 1'b0;
    check("pp count", bus_if.COUNT, 3'd4);
    check("pp overflow", bus_if.OVERFLOW, 1'b0);
    check("pp mod_en", bus_if.MOD_EN, 1'b1);
    check("pp mod_a", bus_if.MOD_A, 16'h0000);
    check("pp mod_wdata", bus_if.MOD_WRITE_DATA, 128'h10);
    tick();
    bus_if.MOD_R = 1'b1;
    tick();
    bus_if.MOD_R = 1'b0;
    check("pp eoi_done", bus_if.MOD_EN, 1'b0);
    ack_eoi("wrap11", 1'b1, 8'h11, 3'd3);
    ack_eoi("wrap12", 1'b0, 8'h12, 3'd2);
    ack_eoi("wrap13", 1'b1, 8'h13, 3'd1);
    ack_eoi("wrap77", 1'b1, 8'h77, 3'd0);

    // INTERRUPT during an outstanding EOI
    capture(1'b0, 8'h55, 1);
    bus_if.INT_ACK = 1'b1;
    tick();
    bus_if.INT_ACK = 1'b0;
    check("err mod_en", bus_if.MOD_EN, 1'b1);
    bus_if.INTERRUPT = 1'b1;
    tick();
    bus_if.INTERRUPT = 1'b0;
    check("err flag", bus_if.ERR, 1'b1);
    check("err count", bus_if.COUNT, 3'd0);
    tick();
    bus_if.MOD_READ_DATA = {119'b0, 1'b0, 8'h99};
    bus_if.MOD_R = 1'b1;
    tick();
    bus_if.MOD_R = 1'b0;
    check("err eoi_done", bus_if.MOD_EN, 1'b0);
    check("err no_push", bus_if.COUNT, 3'd0);
    check("err sticky", bus_if.ERR, 1'b1);

    // Asynchronous reset while an EOI is outstanding
    for (int i = 0; i < 5; i++) capture(1'b1, 8'(8'h60 + i), 1);
    check("pre_rst overflow", bus_if.OVERFLOW, 1'b1);
    bus_if.INT_ACK = 1'b1;
    tick();
    bus_if.INT_ACK = 1'b0;
    check("pre_rst mod_en", bus_if.MOD_EN, 1'b1);
    check("pre_rst count", bus_if.COUNT, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst mod_en", bus_if.MOD_EN, 1'b0);
    check("arst mod_wr", bus_if.MOD_WR, 1'b0);
    check("arst int_req", bus_if.INT_REQ, 1'b0);
    check("arst count", bus_if.COUNT, 3'd0);
    check("arst overflow", bus_if.OVERFLOW, 1'b0);
    check("arst err", bus_if.ERR, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst req", bus_if.INT_REQ, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/intr_eoi_queue.md
# intr_eoi_queue

Interrupt work unit directly upstream of the interrupt bus controller. It consumes the controller's INTERRUPT pulse and completed 128-bit read buffer, and queues up to DEPTH interrupt records (vector plus source). It presents the head record to the CPU with a request/acknowledge handshake. On each acknowledge it drives the controller's module-side request port to write an end-of-interrupt (EOI) message back to the originating device (KBD or DMA).

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- EOI_ADDR_KBD, 16'h0000: EOI target address for KBD; bits [4:2] must be 0.
- EOI_ADDR_DMA, 16'h0010: EOI target address for DMA; bits [4:2] must be nonzero.
- BUS_CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- INTERRUPT  in  1  one-cycle pulse from the bus controller: a device has begun an interrupt write.
- MOD_R  in  1  one-cycle pulse from the bus controller: the current transfer is done.
- MOD_READ_DATA  in  128  controller data buffer; [7:0] = vector, [8] = source (0 = KBD, 1 = DMA).
- MOD_EN  out  1  request to the controller; held until MOD_R.
- MOD_WR  out  1  1 = write; equals MOD_EN.
- MOD_A  out  16  EOI address.
- MOD_WRITE_DATA  out  128  {120'b0, vector}.
- INT_REQ  out  1  head record is valid and offered to the CPU.
- INT_VEC  out  8  head vector; valid while INT_REQ = 1.
- INT_SRC  out  1  head source bit.
- INT_ACK  in  1  CPU accepts the head record; one cycle.
- COUNT  out  log2(DEPTH)+1  occupancy.
- OVERFLOW  out  1  sticky: a record was dropped because the queue was full.
- ERR  out  1  sticky: INTERRUPT arrived while an EOI was in flight.

## Operation
- Reset values: all outputs are 0; the queue is empty; both FSMs are in their idle states; read and write pointers are 0.
- Capture FSM states: C_IDLE and C_WAIT.
  - C_IDLE -> C_WAIT on INTERRUPT=1 when the EOI FSM is in E_IDLE.
  - C_WAIT -> C_IDLE on MOD_R=1. At that edge, push {MOD_READ_DATA[8], MOD_READ_DATA[7:0]}.
  - An INTERRUPT pulse while already in C_WAIT is ignored.
- Full queue on push: the record is dropped and OVERFLOW is set. Exception: if a pop occurs at the same edge, the push is accepted.
- EOI FSM states: E_IDLE and E_BUSY.
  - E_IDLE -> E_BUSY on a pop, i.e. an edge where INT_REQ=1 and INT_ACK=1.
  - At that edge, latch the popped vector and source into the EOI registers.
  - In E_BUSY: MOD_EN=MOD_WR=1. MOD_A is EOI_ADDR_DMA if the source is 1, else EOI_ADDR_KBD. MOD_WRITE_DATA = {120'b0, vector}.
  - E_BUSY -> E_IDLE on MOD_R=1 while the capture FSM is in C_IDLE. MOD_EN, MOD_WR, MOD_A and MOD_WRITE_DATA all return to 0.
- MOD_R ownership: MOD_R belongs to the capture FSM whenever it is in C_WAIT. Otherwise it belongs to the EOI FSM.
- INTERRUPT while in E_BUSY: set ERR. Capture does not start.
- INT_REQ = (COUNT != 0) and EOI FSM is in E_IDLE. The CPU never sees a new head while an EOI is outstanding.
- INT_ACK while INT_REQ=0 is ignored.
- Pointers wrap modulo DEPTH. COUNT changes as follows: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Reset is asynchronous. Asserting RST mid-EOI drops MOD_EN immediately and discards all queued records. OVERFLOW and ERR clear only on reset.

## Timing
- Capture latency: MOD_R edge -> entry written -> INT_REQ high in the following cycle if the queue was empty. Total is one cycle after the MOD_R edge.
- Pop latency: ack edge -> INT_REQ low and MOD_EN high in the same next cycle. Both outputs are registered.
- EOI completion: MOD_R edge -> MOD_EN low next cycle. INT_REQ may reassert in that same cycle if COUNT != 0.
- INT_VEC and INT_SRC follow the read pointer combinationally from the registered array. They are stable while INT_REQ=1 and no pop occurs.
- No combinational path from INT_ACK, INTERRUPT or MOD_R to any output.

## Test plan
- Reset, then capture one record:
  - Stimulus: INTERRUPT pulse; 4 cycles later MOD_R with MOD_READ_DATA[8:0] = 9'h042.
  - Required: INT_REQ=1, INT_VEC=8'h42, INT_SRC=0, COUNT=1 one cycle after MOD_R.
- Acknowledge and EOI:
  - Stimulus: INT_ACK with the record 9'h1A5 at the head; later, MOD_R.
  - Required after ack: next cycle MOD_EN=MOD_WR=1, MOD_A=16'h0010, MOD_WRITE_DATA=128'hA5, INT_REQ=0.
  - Required after MOD_R: MOD_EN=0 next cycle.
- Fill and overflow:
  - Stimulus: 5 captures (vectors 1..5) with no acks.
  - Required: COUNT=4, OVERFLOW=1.
  - Then 4 ack/EOI rounds yield INT_VEC 1,2,3,4 in order, and COUNT ends at 0.
- Simultaneous push and pop with a full queue:
  - Stimulus: capture MOD_R on the same edge as INT_ACK.
  - Required: COUNT stays 4, OVERFLOW stays 0, the new vector lands at the tail, the pointers wrap.
- Error path:
  - Stimulus: INTERRUPT while in E_BUSY.
  - Required: ERR=1, COUNT unchanged, the capture FSM stays in C_IDLE, and the next MOD_R completes the EOI.
- Asynchronous reset mid-EOI:
  - Stimulus: drop RST between edges while MOD_EN=1.
  - Required: MOD_EN, INT_REQ, COUNT, OVERFLOW and ERR are 0 immediately, before the next edge.
